// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with a global stall, DAZ/FTZ handling,
// round-to-nearest-even and a sideband tag carried alongside each operation.
module fp_mul_pipe #(
  parameter int unsigned EXP_BITS = 8,
  parameter int unsigned MAN_BITS = 23,
  parameter int unsigned TAG_BITS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1+EXP_BITS+MAN_BITS-1:0] a,
  input  logic [1+EXP_BITS+MAN_BITS-1:0] b,
  input  logic [TAG_BITS-1:0]            in_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [1+EXP_BITS+MAN_BITS-1:0] result,
  output logic [TAG_BITS-1:0]            out_tag,
  output logic [3:0]                     flags
);

  localparam int unsigned WIDTH     = 1 + EXP_BITS + MAN_BITS;
  localparam int unsigned BIAS      = (1 << (EXP_BITS - 1)) - 1;
  localparam int unsigned SIG_BITS  = MAN_BITS + 1;
  localparam int unsigned PROD_BITS = 2 * SIG_BITS;
  localparam int unsigned EW        = EXP_BITS + 2;
  localparam int unsigned MR_BITS   = MAN_BITS + 1;

  localparam logic [EW-1:0]    EXP_MAX = EW'((1 << EXP_BITS) - 1);
  localparam logic [WIDTH-1:0] QNAN    = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};

  typedef struct packed {
    logic                sign;
    logic                nan;
    logic                snan;
    logic                inf;
    logic                zero;
    logic [EXP_BITS-1:0] exp;
    logic [SIG_BITS-1:0] sig;
  } op_t;

  // Classify one operand; subnormals collapse to zero (DAZ).
  function automatic op_t unpack(input logic [WIDTH-1:0] x);
    op_t  o;
    logic exp_ones;
    logic exp_zero;
    logic man_zero;
    exp_ones = &x[WIDTH-2 -: EXP_BITS];
    exp_zero = ~|x[WIDTH-2 -: EXP_BITS];
    man_zero = ~|x[MAN_BITS-1:0];
    o.sign   = x[WIDTH-1];
    o.exp    = x[WIDTH-2 -: EXP_BITS];
    o.sig    = {1'b1, x[MAN_BITS-1:0]};
    o.nan    = exp_ones && !man_zero;
    o.snan   = exp_ones && !man_zero && !x[MAN_BITS-1];
    o.inf    = exp_ones && man_zero;
    o.zero   = exp_zero;
    return o;
  endfunction

  logic advance;

  logic                s1_valid;
  logic [TAG_BITS-1:0] s1_tag;
  op_t                 s1_a;
  op_t                 s1_b;

  logic                 s2_valid;
  logic [TAG_BITS-1:0]  s2_tag;
  logic                 s2_sign;
  logic                 s2_nan;
  logic                 s2_invalid;
  logic                 s2_inf;
  logic                 s2_zero;
  logic [PROD_BITS-1:0] s2_prod;
  logic [EW-1:0]        s2_exp;

  logic                 nan_d;
  logic                 invalid_d;
  logic [PROD_BITS-1:0] prod_d;
  logic [EW-1:0]        exp_d;

  logic [PROD_BITS-2:0] norm;
  logic [EW-1:0]        exp_norm;
  logic [MAN_BITS-1:0]  man_keep;
  logic                 guard_bit;
  logic                 rnd_bit;
  logic                 sticky;
  logic                 round_up;
  logic [MR_BITS-1:0]   man_rnd;
  logic [EW-1:0]        exp_rnd;
  logic                 inexact;
  logic                 overflow;
  logic                 underflow;
  logic [WIDTH-1:0]     pack_result;
  logic [3:0]           pack_flags;

  // One global enable: the whole pipe moves only when the output slot can be refilled.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // S1: unpack and classify
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      s1_tag <= in_tag;
      s1_a   <= unpack(a);
      s1_b   <= unpack(b);
    end
  end

  // S2: special-case resolution, significand product, unrounded exponent
  always_comb begin
    nan_d     = s1_a.nan || s1_b.nan || (s1_a.inf && s1_b.zero) || (s1_b.inf && s1_a.zero);
    invalid_d = s1_a.snan || s1_b.snan || (s1_a.inf && s1_b.zero) || (s1_b.inf && s1_a.zero);
    prod_d    = PROD_BITS'(s1_a.sig) * PROD_BITS'(s1_b.sig);
    exp_d     = EW'(s1_a.exp) + EW'(s1_b.exp) - EW'(BIAS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (advance && s1_valid) begin
      s2_tag     <= s1_tag;
      s2_sign    <= s1_a.sign ^ s1_b.sign;
      s2_nan     <= nan_d;
      s2_invalid <= invalid_d;
      s2_inf     <= s1_a.inf || s1_b.inf;
      s2_zero    <= s1_a.zero || s1_b.zero;
      s2_prod    <= prod_d;
      s2_exp     <= exp_d;
    end
  end

  // S3: normalise so the leading one sits just above the kept mantissa, then RNE round
  always_comb begin
    norm      = s2_prod[PROD_BITS-1] ? s2_prod[PROD_BITS-2:0]
                                     : {s2_prod[PROD_BITS-3:0], 1'b0};
    exp_norm  = s2_exp + EW'(s2_prod[PROD_BITS-1]);
    man_keep  = norm[PROD_BITS-2 -: MAN_BITS];
    guard_bit = norm[MAN_BITS];
    rnd_bit   = norm[MAN_BITS-1];
    sticky    = |norm[MAN_BITS-2:0];
    round_up  = guard_bit && (rnd_bit || sticky || man_keep[0]);
    man_rnd   = {1'b0, man_keep} + MR_BITS'(round_up);
    // A carry out leaves the mantissa field all-zero, i.e. 1.0 at the next exponent.
    exp_rnd   = exp_norm + EW'(man_rnd[MAN_BITS]);
    inexact   = guard_bit || rnd_bit || sticky;
    overflow  = $signed(exp_rnd) >= $signed(EXP_MAX);
    underflow = exp_rnd[EW-1] || (exp_rnd == '0);

    pack_result = {s2_sign, exp_rnd[EXP_BITS-1:0], man_rnd[MAN_BITS-1:0]};
    pack_flags  = {3'b000, inexact};
    if (s2_nan) begin
      pack_result = QNAN;
      pack_flags  = {s2_invalid, 3'b000};
    end else if (s2_inf) begin
      pack_result = {s2_sign, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
      pack_flags  = 4'b0000;
    end else if (s2_zero) begin
      pack_result = {s2_sign, {(WIDTH-1){1'b0}}};
      pack_flags  = 4'b0000;
    end else if (overflow) begin
      pack_result = {s2_sign, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
      pack_flags  = 4'b0101;
    end else if (underflow) begin
      pack_result = {s2_sign, {(WIDTH-1){1'b0}}};
      pack_flags  = 4'b0011;
    end
  end

  // Output register doubles as the S3 stage; it holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
      flags     <= '0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        result  <= pack_result;
        out_tag <= s2_tag;
        flags   <= pack_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe (FP32 defaults): arithmetic vectors, specials,
// stall/back-to-back streaming and reset with operations in flight.
module tb_fp_mul_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  out_tag;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  fp_mul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issue one op on an idle pipe and wait (bounded) for its result.
  task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic [3:0] vt,
                        output logic [31:0] r, output logic [3:0] f, output logic [3:0] t,
                        output int lat);
    @(negedge clk);
    a = va; b = vb; in_tag = vt; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = result; f = flags; t = out_tag;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 32'h3F800000; b = 32'h40000000; in_tag = 4'hF;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_tag: got %h expected 0", out_tag); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_rounding();
    vec_t        v [7];
    logic [31:0] r;
    logic [3:0]  f;
    logic [3:0]  t;
    int          lat;
    v[0] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000}; // 1.5*2 exact
    v[1] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001}; // sticky only
    v[2] = '{32'h3FC00001, 32'h3FC00000, 32'h40100001, 4'b0001}; // guard+round, up
    v[3] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001}; // tie, odd -> up
    v[4] = '{32'h3F800002, 32'h3FA00000, 32'h3FA00002, 4'b0001}; // tie, even -> stay
    v[5] = '{32'h3FA1E58F, 32'h3FCA6691, 32'h40000000, 4'b0001}; // 2^47-1 product, carry
    v[6] = '{32'h7F000000, 32'h3FFFFFFF, 32'h7F7FFFFF, 4'b0000}; // largest finite
    for (int i = 0; i < 7; i++) begin
      run_op(v[i].a, v[i].b, 4'(i + 5), r, f, t, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL round%0d_latency: got %0d expected 3", i, lat); end
      checks++; if (r !== v[i].r) begin errors++; $display("FAIL round%0d_result: got %h expected %h", i, r, v[i].r); end
      checks++; if (f !== v[i].f) begin errors++; $display("FAIL round%0d_flags: got %b expected %b", i, f, v[i].f); end
      checks++; if (t !== 4'(i + 5)) begin errors++; $display("FAIL round%0d_tag: got %h expected %h", i, t, 4'(i + 5)); end
    end
  endtask

  task automatic test_range();
    vec_t        v [4];
    logic [31:0] r;
    logic [3:0]  f;
    logic [3:0]  t;
    int          lat;
    v[0] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101};
    v[1] = '{32'hFF000000, 32'h7F000000, 32'hFF800000, 4'b0101};
    v[2] = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011};
    v[3] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      run_op(v[i].a, v[i].b, 4'(i + 1), r, f, t, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL range%0d_latency: got %0d expected 3", i, lat); end
      checks++; if (r !== v[i].r) begin errors++; $display("FAIL range%0d_result: got %h expected %h", i, r, v[i].r); end
      checks++; if (f !== v[i].f) begin errors++; $display("FAIL range%0d_flags: got %b expected %b", i, f, v[i].f); end
    end
  endtask

  task automatic test_specials();
    vec_t        v [8];
    logic [31:0] r;
    logic [3:0]  f;
    logic [3:0]  t;
    int          lat;
    v[0] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000}; // inf*0
    v[1] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000}; // qNaN
    v[2] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000}; // sNaN
    v[3] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000}; // -inf*2
    v[4] = '{32'h80000000, 32'h40400000, 32'h80000000, 4'b0000}; // -0*3
    v[5] = '{32'h7F800000, 32'hFF800000, 32'hFF800000, 4'b0000}; // inf*-inf
    v[6] = '{32'hFFC00000, 32'h7F800000, 32'h7FC00000, 4'b0000}; // -qNaN canonicalised
    v[7] = '{32'h80000001, 32'h7F800000, 32'h7FC00000, 4'b1000}; // DAZ subnormal * inf
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].a, v[i].b, 4'(15 - i), r, f, t, lat);
      checks++; if (r !== v[i].r) begin errors++; $display("FAIL special%0d_result: got %h expected %h", i, r, v[i].r); end
      checks++; if (f !== v[i].f) begin errors++; $display("FAIL special%0d_flags: got %b expected %b", i, f, v[i].f); end
      checks++; if (t !== 4'(15 - i)) begin errors++; $display("FAIL special%0d_tag: got %h expected %h", i, t, 4'(15 - i)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_r [8];
    logic [3:0]  exp_t [8];
    logic [31:0] held_r;
    logic [3:0]  held_t;
    logic [3:0]  held_f;
    logic        stalled_prev;
    int          issued;
    int          got;
    int          cyc;
    int          extra;
    issued = 0; got = 0; cyc = 0; extra = 0; stalled_prev = 1'b0;
    held_r = '0; held_t = '0; held_f = '0;
    // 2.0 * x only bumps the exponent field, so each result is x + 0x00800000.
    for (int k = 0; k < 8; k++) begin
      exp_r[k] = 32'h3F800000 + 32'(k) * 32'h00100000 + 32'h00800000;
      exp_t[k] = 4'(k + 3);
    end
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc < 9);
      if (issued < 8) begin
        a = 32'h40000000; b = 32'h3F800000 + 32'(issued) * 32'h00100000;
        in_tag = 4'(issued + 3); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled_prev) begin
        checks++; if (result !== held_r) begin errors++; $display("FAIL stall_result_hold: got %h expected %h", result, held_r); end
        checks++; if (out_tag !== held_t) begin errors++; $display("FAIL stall_tag_hold: got %h expected %h", out_tag, held_t); end
        checks++; if (flags !== held_f) begin errors++; $display("FAIL stall_flags_hold: got %b expected %b", flags, held_f); end
      end
      if (out_valid && !out_ready) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
      end
      stalled_prev = out_valid && !out_ready;
      held_r = result; held_t = out_tag; held_f = flags;
      if (out_valid && out_ready) begin
        if (got < 8) begin
          checks++; if (result !== exp_r[got]) begin errors++; $display("FAIL stream%0d_result: got %h expected %h", got, result, exp_r[got]); end
          checks++; if (out_tag !== exp_t[got]) begin errors++; $display("FAIL stream%0d_tag: got %h expected %h", got, out_tag, exp_t[got]); end
          checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL stream%0d_flags: got %b expected 0000", got, flags); end
        end
        got++;
      end
      if (in_valid && in_ready) issued++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got !== 8) begin errors++; $display("FAIL stream_delivered: got %0d expected 8", got); end
    checks++; if (issued !== 8) begin errors++; $display("FAIL stream_issued: got %0d expected 8", issued); end
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL stream_duplicates: got %0d expected 0", extra); end
  endtask

  task automatic test_reset_in_flight();
    logic [31:0] r;
    logic [3:0]  f;
    logic [3:0]  t;
    int          lat;
    int          leak;
    leak = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a = 32'h40000000; b = 32'h40000000; in_tag = 4'(k + 1); in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flight%0d_accept: got %b expected 1", k, in_ready); end
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL flight_result: got %h expected 00000000", result); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL flight_tag: got %h expected 0", out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flight_in_ready: got %b expected 1", in_ready); end
    repeat (6) begin
      @(negedge clk);
      if (out_valid) leak++;
    end
    checks++; if (leak !== 0) begin errors++; $display("FAIL flight_leak: got %0d expected 0", leak); end
    run_op(32'h3FC00000, 32'h40000000, 4'h9, r, f, t, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL post_reset_latency: got %0d expected 3", lat); end
    checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL post_reset_result: got %h expected 40400000", r); end
    checks++; if (t !== 4'h9) begin errors++; $display("FAIL post_reset_tag: got %h expected 9", t); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; in_tag = '0; out_ready = 1'b1;
    test_reset();
    test_rounding();
    test_range();
    test_specials();
    test_back_to_back();
    test_reset_in_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_BITS, default 8: exponent field width; legal range 4..11.
REQ-002 SHALL have parameter MAN_BITS, default 23: stored mantissa width; legal range 3..52.
REQ-003 SHALL have parameter TAG_BITS, default 4: sideband tag width, carried unchanged alongside each operation.
REQ-004 SHALL derive localparam WIDTH = 1+EXP_BITS+MAN_BITS and BIAS = 2^(EXP_BITS-1)-1.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  operand pair a/b/in_tag presented.
REQ-008 in_ready  output  1  block accepts the operand pair this cycle.
REQ-009 a, b  input  WIDTH each  IEEE-style operands: {sign, exponent, mantissa}.
REQ-010 in_tag  input  TAG_BITS  sideband tag.
REQ-011 out_valid  output  1  result/flags/out_tag valid.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 result  output  WIDTH  product.
REQ-014 out_tag  output  TAG_BITS  tag of the producing operation.
REQ-015 flags  output  4  {invalid, overflow, underflow, inexact}.

Function
REQ-016 SHALL be a 3-stage pipeline: S1 unpack/classify, S2 mantissa multiply plus exponent add, S3 normalise, round, pack into output register.
REQ-017 SHALL accept an operation when in_valid && in_ready; latency SHALL be exactly 3 cycles from acceptance to out_valid when no stall occurs.
REQ-018 SHALL stall globally: advance = !out_valid || out_ready; in_ready = advance; when !advance, every stage register SHALL hold.
REQ-019 Bubbles SHALL NOT be collapsed; each stage carries its own valid bit; sustained throughput SHALL be 1 op/cycle when out_ready is high.
REQ-020 result, out_tag and flags SHALL remain stable while out_valid && !out_ready.
REQ-021 Subnormal inputs (exp==0, man!=0) SHALL be treated as signed zero (DAZ); no flag is raised for this.
REQ-022 Result sign SHALL be sign(a) XOR sign(b) for all non-NaN results.
REQ-023 Any NaN input or inf*0 SHALL produce canonical NaN: sign 0, exp all ones, mantissa MSB 1, other bits 0.
REQ-024 invalid SHALL be set for inf*0 or any signalling NaN input (exp all ones, mantissa MSB 0, mantissa nonzero); a quiet NaN input SHALL NOT set invalid.
REQ-025 inf * finite-nonzero or inf * inf SHALL give signed infinity with no flags; zero * finite SHALL give signed zero with no flags.
REQ-026 Normal path: full (MAN_BITS+1)x(MAN_BITS+1) product; biased exponent computed with EXP_BITS+2 signed bits to avoid wrap.
REQ-027 Normalisation SHALL right-shift by 1 and increment the exponent when product MSB is set.
REQ-028 Rounding SHALL be round-to-nearest-even using guard bit, round bit and sticky OR of all lower bits; a mantissa carry-out from rounding SHALL renormalise and increment the exponent.
REQ-029 inexact SHALL be set when any discarded bit is nonzero.
REQ-030 Post-rounding exponent >= 2^EXP_BITS-1 SHALL yield signed infinity with overflow=1 and inexact=1.
REQ-031 Post-rounding exponent <= 0 SHALL yield signed zero (FTZ) with underflow=1 and inexact=1.
REQ-032 in_tag SHALL travel with its operation and appear on out_tag with the result.

Reset
REQ-033 While rst is high at a clock edge, all stage valid bits SHALL clear; out_valid SHALL be 0 and result, out_tag, flags SHALL be 0 from the following cycle.
REQ-034 Operations in flight at reset SHALL be discarded; in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification (FP32 defaults)
REQ-035 a=0x3FC00000, b=0x40000000, tag 5 -> 3 cycles later result=0x40400000, flags=0000, out_tag=5.
REQ-036 a=b=0x3F800001 -> result=0x3F800002, flags=0001 (inexact only, RNE).
REQ-037 a=b=0x7F000000 -> result=0x7F800000, flags=0101; a=0x7F800000, b=0x00000000 -> 0x7FC00000, flags=1000.
REQ-038 a=b=0x00800000 -> result=0x00000000, flags=0011; a=0x00000001 (subnormal), b=0x3F800000 -> 0x00000000, flags=0000.
REQ-039 Stream 8 ops back-to-back, out_ready held low 4 cycles mid-stream -> in_ready low during stall, outputs stable, all 8 results delivered in order with correct tags, none lost or duplicated.
REQ-040 Assert rst for 1 cycle with 3 ops in flight -> out_valid 0 next cycle, none of the 3 ops ever emitted, new op after reset completes in 3 cycles.
